updown_modn_counter: RTL
========================

Name: updown_modn_counter

Overview:
- Parametrised up/down modulo-N counter.
- Steps only on a programmable clock-enable tick. There is no derived clock: everything runs on the single `clk` domain.
- Provides synchronous load with defined priority, plus terminal-count and wrap indications.
- Used as the generic timing/count primitive for display, sequencing and timeout blocks in the design.

Parameters:
- WIDTH, 4, count register width in bits.
- MODULUS, 16, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH.
- PRESCALE, 6, clk cycles per count step. 1 means step every enabled cycle. Legal range PRESCALE >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable. Low freezes both the prescaler and the counter.
- up  in  1  direction: 1 = increment, 0 = decrement. Sampled on step cycles.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- step  out  1  registered one-cycle pulse, high in the cycle after count changed due to stepping.
- wrap  out  1  registered one-cycle pulse, high in the cycle after a wrap-around step.
- tc  out  1  combinational terminal count: (up && count==MODULUS-1) || (!up && count==0).

Behaviour:
- Reset has top priority at the clk edge.
  - count=0, internal prescaler pre=0, step=0, wrap=0.
  - tc then follows its equation.
- Prescaler pre has width clog2(PRESCALE), with a minimum of 1 bit.
  - Advances when en=1 and load=0.
  - When pre==PRESCALE-1 it returns to 0 and the cycle is a step cycle.
  - For PRESCALE=1 every enabled cycle is a step cycle.
- Step cycle, up=1: count<=count+1, except count==MODULUS-1 gives count<=0 and sets wrap<=1.
- Step cycle, up=0: count<=count-1, except count==0 gives count<=MODULUS-1 and sets wrap<=1.
- step<=1 on every step cycle, 0 otherwise. wrap<=0 on non-wrap cycles.
- Load:
  - When load=1 (and reset=0): count<=load_val, pre<=0, step<=0, wrap<=0.
  - Load ignores en and takes precedence over a coincident step; no step is applied that cycle.
  - If load_val >= MODULUS, count<=MODULUS-1 (clamp).
- en=0: count, pre and direction state hold; step=0, wrap=0. Re-asserting en resumes from the held pre value, so no partial-period loss.
- Direction change mid-period: takes effect at the next step cycle. The prescaler is not restarted.
- Latency:
  - Load visible on count 1 cycle after the strobe.
  - First step after a load occurs PRESCALE enabled cycles later.
- Reset asserted mid-operation overrides load and en in the same cycle.
- Arithmetic is done in WIDTH bits. Count is never observed outside 0..MODULUS-1 except transiently if held illegally. Illegal parameter values are rejected by an elaboration-time check.

Decomposition:
- Shared package: direction constants DIR_UP=1, DIR_DOWN=0.
- One sub-module, tick_gen:
  - Parameter PRESCALE.
  - Inputs clk, reset, en, clear. Output tick.
  - Contains the pre counter.
  - Reusable by other blocks needing a clock enable.
- The counter/load/wrap logic stays in updown_modn_counter.

Test Plan (WIDTH=4, MODULUS=10, PRESCALE=3 unless noted):
- reset=1 for 2 cycles, then en=1, up=1, held 30 cycles:
  - count steps 0->1->...->9->0, one step every 3rd cycle.
  - wrap pulses once, the cycle after 9->0.
  - tc=1 while count=9.
- load=1, load_val=2, up=0, en=1:
  - count=2 the next cycle, then 1, 0, 9 at 3-cycle intervals.
  - wrap pulses after 0->9; tc=1 at count 0.
- load=1 with load_val=13 coincident with a step cycle: count=9 (clamped), no step, step=0, wrap=0, pre restarts.
- en=0 for 5 cycles at pre=1, then en=1: count holds, step stays 0; next step occurs exactly 2 enabled cycles after re-enable.
- PRESCALE=1, MODULUS=16, up=1 from load_val=15: count 15->0 on the next cycle with wrap=1, then increments every cycle.
- reset=1 asserted together with load=1, load_val=5 mid-count: count=0, step=0, wrap=0. Load is ignored.

Source files
------------

// File: rtl/updown_modn_counter_pkg.sv
// Shared constants and helpers for the up/down modulo-N counter family.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package updown_modn_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Prescaler register width: clog2 of the period, never narrower than 1 bit.
  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/updown_modn_counter_tick_gen.sv
// Clock-enable generator: one-cycle tick every PRESCALE enabled cycles.
// Latency: tick is combinational from the prescaler state and en/clear.
// Backpressure: en low freezes the prescaler; clear restarts the period.
module tick_gen
  import updown_modn_counter_pkg::*;
#(
  parameter int PRESCALE = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int PW = pre_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic          w_last;

  assign w_last = (r_pre == LAST);
  assign tick   = en & ~clear & w_last;

  // Prescaler: restart on reset/clear, advance only while enabled, roll over at LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
    end else if (clear) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_last ? '0 : r_pre + PW'(1);
    end
  end

endmodule

// File: rtl/updown_modn_counter.sv
// Up/down modulo-MODULUS counter stepping on a prescaled tick, with clamped load.
// Latency: load and step visible on count one cycle after the strobe/tick; step/wrap registered.
// Backpressure: en low holds count and prescaler; load overrides en and any coincident step.
module updown_modn_counter
  import updown_modn_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             wrap,
  output logic             tc
);

  // Reject parameter sets the counter cannot represent.
  if (MODULUS < 2 || MODULUS > (1 << WIDTH) || PRESCALE < 1) begin : g_bad_params
    $error("updown_modn_counter: illegal WIDTH/MODULUS/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_step;
  logic             r_wrap;
  logic             w_tick;
  logic [WIDTH-1:0] w_load_clamped;

  // The tick generator is cleared by load so the first step after a load is a full period away.
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clear (load),
    .tick  (w_tick)
  );

  assign w_load_clamped = (load_val > MAX) ? MAX : load_val;

  // Count register: reset > load > step; step/wrap pulse only on the cycle after a step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_tick) begin
      r_step <= 1'b1;
      if (up == DIR_UP) begin
        if (r_count == MAX) begin
          r_count <= '0;
          r_wrap  <= 1'b1;
        end else begin
          r_count <= r_count + WIDTH'(1);
          r_wrap  <= 1'b0;
        end
      end else begin
        if (r_count == '0) begin
          r_count <= MAX;
          r_wrap  <= 1'b1;
        end else begin
          r_count <= r_count - WIDTH'(1);
          r_wrap  <= 1'b0;
        end
      end
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign count = r_count;
  assign step  = r_step;
  assign wrap  = r_wrap;
  assign tc    = ((up == DIR_UP) && (r_count == MAX)) ||
                 ((up == DIR_DOWN) && (r_count == '0));

endmodule
